// File: rtl/instr_cycle_sequencer.sv
// rtl/instr_cycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for KGPminiRISC
//
// Purpose: steps each instruction through its cycles and turns the control
// unit's level-valued decode signals into per-cycle enables.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    leave IDLE and begin fetching
//   opcode                   IR opcode field (HALT_OP halts)
//   regWrite_in .. branch_in control unit decode levels
//   mem_ready                memory completes the current access this cycle
//   pc_write, ir_write       one-cycle PC / IR load enables
//   reg_write                register-file write enable
//   mem_read, mem_write      memory requests, mem_ifetch marks a fetch
//   busy, halted, fault      status; state is the raw state encoding
//   retired                  retired-instruction count (SEQ_RETIRE_CNT_EN only)
// Optional feature macro: SEQ_RETIRE_CNT_EN

module instr_cycle_sequencer #(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [5:0] HALT_OP     = 6'b111111,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             regWrite_in,
    input  logic             memRead_in,
    input  logic             memWrite_in,
    input  logic             branch_in,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_ifetch,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO     = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = {TW{1'b1}};

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0] tmo_inc;
    logic          waiting;
    logic          timed_out;

    // branch_in is informational only: the datapath picks the PC source.
    logic unused_branch;
    assign unused_branch = branch_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_ifetch = 1'b0;
        waiting    = 1'b0;

        // Saturating increment; the timeout compares the post-increment
        // value, so the ERR transition happens on the MEM_TIMEOUT-th wait.
        tmo_inc   = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        timed_out = (MEM_TIMEOUT > 0) && (tmo_inc == TMO);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read   = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OP)              state_d = S_HALT;
                else if (memRead_in && memWrite_in) state_d = S_ERR;
                else                                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (memRead_in || memWrite_in) begin
                    state_d = S_MEM;
                end else if (regWrite_in) begin
                    state_d = S_WB;
                end else begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                mem_read  = memRead_in;
                mem_write = memWrite_in;
                if (mem_ready) begin
                    // Loads retire through WB; anything else retires here.
                    if (memRead_in) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    waiting = 1'b1;
                    if (timed_out) state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Any state change clears the counter, which covers every entry
        // into FETCH or MEM; staying put while waiting counts up.
        if (state_d != state_q) tmo_cnt_d = '0;
        else if (waiting)       tmo_cnt_d = tmo_inc;
        else                    tmo_cnt_d = tmo_cnt_q;
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
    assign halted = (state_q == S_HALT);
    assign fault  = (state_q == S_ERR);
    assign state  = state_q;

`ifdef SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = pc_write ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// tb/tb_instr_cycle_sequencer.sv - directed self-checking bench for instr_cycle_sequencer

module tb_instr_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] opcode;
    logic       regWrite_in, memRead_in, memWrite_in, branch_in;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_ifetch;
    logic       busy, halted, fault;
    logic [2:0] state;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    instr_cycle_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opcode      (opcode),
        .regWrite_in (regWrite_in),
        .memRead_in  (memRead_in),
        .memWrite_in (memWrite_in),
        .branch_in   (branch_in),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_ifetch  (mem_ifetch),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .state       (state)
`ifdef SEQ_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;

    // Output vector: {pc, ir, rw, mr, mw, ifetch, busy, halted, fault}
    localparam logic [8:0] O_ZERO   = 9'b000000000;
    localparam logic [8:0] O_F_RDY  = 9'b010101100;
    localparam logic [8:0] O_F_WAIT = 9'b000101100;
    localparam logic [8:0] O_BUSY   = 9'b000000100;
    localparam logic [8:0] O_WB     = 9'b101000100;
    localparam logic [8:0] O_LD     = 9'b000100100;
    localparam logic [8:0] O_ST_WT  = 9'b000010100;
    localparam logic [8:0] O_ST_RDY = 9'b100010100;
    localparam logic [8:0] O_BR     = 9'b100000100;
    localparam logic [8:0] O_HALT   = 9'b000000010;
    localparam logic [8:0] O_ERR    = 9'b000000001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check state/outputs mid-cycle, then advance to just after the next edge.
    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [8:0] o);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_outs"}, 32'({pc_write, ir_write, reg_write, mem_read, mem_write,
                                   mem_ifetch, busy, halted, fault}), 32'(o));
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rw, input logic mr, input logic mw, input logic br);
        regWrite_in = rw;
        memRead_in  = mr;
        memWrite_in = mw;
        branch_in   = br;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        expect_cycle("idle", 3'd0, O_ZERO);

        // ALU: F D E WB, then back to F
        start = 1'b1;
        expect_cycle("alu_start", 3'd0, O_ZERO);
        start = 1'b0; mem_ready = 1'b1; set_dec(1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle("alu_f", 3'd1, O_F_RDY);
        expect_cycle("alu_d", 3'd2, O_BUSY);
        expect_cycle("alu_e", 3'd3, O_BUSY);
        expect_cycle("alu_wb", 3'd5, O_WB);

        // Load with three MEM wait cycles: F D E M M M M WB = 8 cycles
        set_dec(1'b1, 1'b1, 1'b0, 1'b0);
        expect_cycle("ld_f", 3'd1, O_F_RDY);
        expect_cycle("ld_d", 3'd2, O_BUSY);
        expect_cycle("ld_e", 3'd3, O_BUSY);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle("ld_mwait", 3'd4, O_LD);
        mem_ready = 1'b1;
        expect_cycle("ld_mrdy", 3'd4, O_LD);
        expect_cycle("ld_wb", 3'd5, O_WB);

        // Store: F D E M, pc_write in MEM
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("st_f", 3'd1, O_F_RDY);
        expect_cycle("st_d", 3'd2, O_BUSY);
        expect_cycle("st_e", 3'd3, O_BUSY);
        expect_cycle("st_m", 3'd4, O_ST_RDY);

        // Branch: F D E, pc_write in EXEC
        set_dec(1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("br_f", 3'd1, O_F_RDY);
        expect_cycle("br_d", 3'd2, O_BUSY);
        expect_cycle("br_e", 3'd3, O_BR);
`ifdef SEQ_RETIRE_CNT_EN
        #1 check("retired4", retired, 32'd4);
`endif

        // Reset during a store MEM wait
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("rs_f", 3'd1, O_F_RDY);
        expect_cycle("rs_d", 3'd2, O_BUSY);
        expect_cycle("rs_e", 3'd3, O_BUSY);
        mem_ready = 1'b0;
        expect_cycle("rs_mwait", 3'd4, O_ST_WT);
        rst = 1'b1;
        expect_cycle("rs_mhold", 3'd4, O_ST_WT);
        expect_cycle("rs_idle", 3'd0, O_ZERO);
        rst = 1'b0;

        // Fetch timeout: 15 waiting cycles, then ERR; start ignored
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        expect_cycle("to_start", 3'd0, O_ZERO);
        for (int i = 0; i < 15; i++) expect_cycle("to_fwait", 3'd1, O_F_WAIT);
        expect_cycle("to_err", 3'd7, O_ERR);
        expect_cycle("to_err_start", 3'd7, O_ERR);
        start = 1'b0;
        do_reset();

        // mem_ready on the 15th wait cycle completes normally
        start = 1'b1;
        expect_cycle("bd_start", 3'd0, O_ZERO);
        start = 1'b0;
        for (int i = 0; i < 14; i++) expect_cycle("bd_fwait", 3'd1, O_F_WAIT);
        mem_ready = 1'b1;
        set_dec(1'b0, 1'b1, 1'b1, 1'b0);
        expect_cycle("bd_frdy", 3'd1, O_F_RDY);
        // Illegal decode: memRead & memWrite together
        expect_cycle("il_d", 3'd2, O_BUSY);
        expect_cycle("il_err", 3'd7, O_ERR);
        do_reset();

        // Halt opcode: absorbing, enables zero for 20 cycles
        set_dec(1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        expect_cycle("h_start", 3'd0, O_ZERO);
        opcode = 6'b111111;
        expect_cycle("h_f", 3'd1, O_F_RDY);
        expect_cycle("h_d", 3'd2, O_BUSY);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            expect_cycle("h_halt", 3'd6, O_HALT);
        end
        do_reset();
        expect_cycle("final_idle", 3'd0, O_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
